instr_decode: RTL

- Decode/issue stage sitting directly upstream of the execute stage.
- Accepts 32-bit instruction words from fetch through a valid/ready handshake and reads source operands from the external register file.
- Produces registered one-hot op flags, val1/val2/val3 and forwarding-hazard flags for execute.
- Handles branch flush, the store-data stall and sticky halt.

---
 rtl/instr_decode.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_decode.sv
`default_nettype none
// instr_decode: decode/issue stage feeding execute. Registered one-hot op flags, operands and
// forwarding-hazard flags; handles branch flush, store-data stall and sticky halt.
module instr_decode #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int STORE_STALL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr_word,
    output logic              instr_ready,
    input  logic              flush,
    output logic [3:0]        rs1_addr,
    output logic [3:0]        rs2_addr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              is_add,
    output logic              is_sub,
    output logic              is_and,
    output logic              is_or,
    output logic              is_gt,
    output logic              is_eq,
    output logic              is_mem_write,
    output logic              is_mem_read,
    output logic              is_reg_write,
    output logic              is_branch,
    output logic              is_halt,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] val3,
    output logic              is_val1_data_hazard,
    output logic              is_val2_data_hazard,
    output logic              is_mem_data_hazard,
    output logic              illegal_instr
);
    localparam int CNT_W = (STORE_STALL > 1) ? $clog2(STORE_STALL) : 1;
    localparam int TGT_W = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
    localparam logic [DATA_W-1:0] TGT_MASK = {DATA_W{1'b1}} >> (DATA_W - TGT_W);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [31:0]       held_word;
    logic              trk_valid;
    logic              trk_load;
    logic [3:0]        trk_rd;
    logic [9:0]        op_flags;

    logic [31:0]       cur_word;
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [DATA_W-1:0] imm;

    // While stalled, the held store drives the regfile addresses so its data is read fresh.
    assign cur_word = (state == ST_STALL) ? held_word : instr_word;
    assign op       = cur_word[31:28];
    assign rd       = cur_word[27:24];
    assign rs1_addr = cur_word[23:20];
    assign rs2_addr = cur_word[19:16];
    assign imm      = DATA_W'(cur_word[15:0]);

    assign instr_ready = rst & (flush | (state == ST_RUN));

    // op_flags order: add, sub, and, or, gt, eq, mem_write, mem_read, reg_write, branch
    logic [9:0]        dec_flags;
    logic              dec_halt;
    logic              dec_illegal;
    logic              uses_rs1;
    logic              val2_rs2;
    logic [DATA_W-1:0] dec_val2;
    logic [DATA_W-1:0] dec_val3;

    always_comb begin
        dec_flags   = '0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        uses_rs1    = 1'b0;
        val2_rs2    = 1'b0;
        dec_val2    = '0;
        dec_val3    = '0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                dec_flags        = 10'b0000000010;
                dec_flags[10-op] = 1'b1;
                uses_rs1 = 1'b1;
                val2_rs2 = 1'b1;
                dec_val2 = rs2_data;
                dec_val3 = DATA_W'(rd);
            end
            4'h7, 4'h8: begin
                dec_flags = (op == 4'h8) ? 10'b1000000110 : 10'b1000000010;
                uses_rs1  = 1'b1;
                dec_val2  = imm;
                dec_val3  = DATA_W'(rd);
            end
            4'h9: begin
                dec_flags = 10'b1000001000;
                uses_rs1  = 1'b1;
                dec_val2  = imm;
                dec_val3  = rs2_data;
            end
            4'hA, 4'hB: begin
                dec_flags = (op == 4'hA) ? 10'b0000010001 : 10'b0000100001;
                uses_rs1  = 1'b1;
                val2_rs2  = 1'b1;
                dec_val2  = rs2_data;
                dec_val3  = imm & TGT_MASK;
            end
            4'hC, 4'hD, 4'hE: dec_illegal = 1'b1;
            4'hF:             dec_halt    = 1'b1;
            default: ;
        endcase
    end

    logic haz1;
    logic haz2;
    logic store_hold;
    logic issue;

    assign haz1       = trk_valid & uses_rs1 & (rs1_addr == trk_rd);
    assign haz2       = trk_valid & val2_rs2 & (rs2_addr == trk_rd);
    assign store_hold = (STORE_STALL != 0) && (op == 4'h9) && trk_valid && (rs2_addr == trk_rd);
    assign issue      = (state == ST_STALL) ? (stall_cnt == '0)
                                            : ((state == ST_RUN) && instr_valid && !store_hold);

    assign {is_add, is_sub, is_and, is_or, is_gt, is_eq,
            is_mem_write, is_mem_read, is_reg_write, is_branch} = op_flags;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_RUN;
            stall_cnt           <= '0;
            held_word           <= '0;
            trk_valid           <= 1'b0;
            trk_load            <= 1'b0;
            trk_rd              <= '0;
            op_flags            <= '0;
            is_halt             <= 1'b0;
            illegal_instr       <= 1'b0;
            val1                <= '0;
            val2                <= '0;
            val3                <= '0;
            is_val1_data_hazard <= 1'b0;
            is_val2_data_hazard <= 1'b0;
            is_mem_data_hazard  <= 1'b0;
        end else if (flush) begin
            state               <= ST_RUN;
            stall_cnt           <= '0;
            trk_valid           <= 1'b0;
            op_flags            <= '0;
            is_halt             <= 1'b0;
            illegal_instr       <= 1'b0;
            val1                <= '0;
            val2                <= '0;
            val3                <= '0;
            is_val1_data_hazard <= 1'b0;
            is_val2_data_hazard <= 1'b0;
            is_mem_data_hazard  <= 1'b0;
        end else begin
            op_flags            <= issue ? dec_flags : '0;
            val1                <= (issue && uses_rs1) ? rs1_data : '0;
            val2                <= issue ? dec_val2 : '0;
            val3                <= issue ? dec_val3 : '0;
            illegal_instr       <= issue & dec_illegal;
            is_halt             <= (issue & dec_halt) | (state == ST_HALTED);
            is_val1_data_hazard <= issue & haz1;
            is_val2_data_hazard <= issue & haz2;
            is_mem_data_hazard  <= issue & trk_load & (haz1 | haz2);
            trk_valid           <= issue & dec_flags[1];
            trk_rd              <= rd;
            trk_load            <= dec_flags[2];
            case (state)
                ST_RUN: begin
                    if (instr_valid && store_hold) begin
                        held_word <= instr_word;
                        stall_cnt <= CNT_W'(STORE_STALL - 1);
                        state     <= ST_STALL;
                    end else if (issue && dec_halt) begin
                        state <= ST_HALTED;
                    end
                end
                ST_STALL: begin
                    if (stall_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        stall_cnt <= stall_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
